// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared opcode/funct codes, FSM states and ALU helper for the multi-cycle CPU
package mcpu_pkg;

  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_MADDR = 5'd2,
    S_MRD   = 5'd3,
    S_LWWB  = 5'd4,
    S_MWR   = 5'd5,
    S_REXE  = 5'd6,
    S_RWB   = 5'd7,
    S_BEQ   = 5'd8,
    S_J     = 5'd9,
    S_IEXE  = 5'd10,
    S_IWB   = 5'd11,
    S_JAL   = 5'd12,
    S_JR    = 5'd13,
    S_BNE   = 5'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_PASSB
  } alu_op_t;

  // Shifts act on the second operand (rt) by shamt; PASSB forwards a pre-shifted lui immediate.
  function automatic logic [31:0] alu_eval(input alu_op_t op, input logic [31:0] x,
                                           input logic [31:0] y, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      ALU_ADD:   r = x + y;
      ALU_SUB:   r = x - y;
      ALU_AND:   r = x & y;
      ALU_OR:    r = x | y;
      ALU_XOR:   r = x ^ y;
      ALU_NOR:   r = ~(x | y);
      ALU_SLT:   r = {31'b0, ($signed(x) < $signed(y))};
      ALU_SLL:   r = y << sh;
      ALU_SRL:   r = y >> sh;
      ALU_PASSB: r = y;
      default:   r = x + y;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// rtl/mcpu_regfile.sv - 32x32 register file, two combinational reads, one synchronous write, $0 fixed at zero
module mcpu_regfile
  import mcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [0:31];

  // Clear everything on reset; writes to $0 are dropped so it always reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/multi_cycle_cpu.sv
// rtl/multi_cycle_cpu.sv - multi-cycle MIPS-subset core with a single shared memory/IO port
module multi_cycle_cpu
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MIO_ready,
  input  logic        INT,
  input  logic [31:0] Data_in,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic        mem_w,
  output logic [31:0] Addr_out,
  output logic [31:0] Data_out,
  output logic        CPU_MIO,
  output logic [4:0]  state
);

  state_t      state_q, state_d;
  logic [31:0] pc, ir, a, b, mdr, alu_out;
  logic [31:0] rdata_a, rdata_b, imm_sext, imm_zext, alu_b, alu_res, branch_target;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  alu_op_t     alu_op;

  logic [5:0] op, fn;
  logic [4:0] rs, rt, rd, shamt;

  // Interrupts are reserved; the input is accepted but has no effect.
  logic unused_int;
  assign unused_int = INT;

  assign op            = ir[31:26];
  assign rs            = ir[25:21];
  assign rt            = ir[20:16];
  assign rd            = ir[15:11];
  assign shamt         = ir[10:6];
  assign fn            = ir[5:0];
  assign imm_sext      = {{16{ir[15]}}, ir[15:0]};
  assign imm_zext      = {16'h0000, ir[15:0]};
  assign branch_target = pc + {imm_sext[29:0], 2'b00};

  mcpu_regfile u_regs (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ALU operation and second operand: register B in REXE, an extended immediate otherwise.
  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = b;
    if (state_q == S_REXE) begin
      case (fn)
        FN_SUB:  alu_op = ALU_SUB;
        FN_AND:  alu_op = ALU_AND;
        FN_OR:   alu_op = ALU_OR;
        FN_XOR:  alu_op = ALU_XOR;
        FN_NOR:  alu_op = ALU_NOR;
        FN_SLT:  alu_op = ALU_SLT;
        FN_SLL:  alu_op = ALU_SLL;
        FN_SRL:  alu_op = ALU_SRL;
        default: alu_op = ALU_ADD;
      endcase
    end else begin
      alu_b = imm_sext;
      case (op)
        OP_SLTI: alu_op = ALU_SLT;
        OP_ANDI: begin alu_op = ALU_AND; alu_b = imm_zext; end
        OP_ORI:  begin alu_op = ALU_OR;  alu_b = imm_zext; end
        OP_XORI: begin alu_op = ALU_XOR; alu_b = imm_zext; end
        OP_LUI:  begin alu_op = ALU_PASSB; alu_b = {ir[15:0], 16'h0000}; end
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  assign alu_res = alu_eval(alu_op, a, alu_b, shamt);

  // Register-file write port: only the writeback states and JAL write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rt;
    rf_wdata = alu_out;
    case (state_q)
      S_RWB:   begin rf_we = 1'b1; rf_waddr = rd; end
      S_IWB:   rf_we = 1'b1;
      S_LWWB:  begin rf_we = 1'b1; rf_wdata = mdr; end
      S_JAL:   begin rf_we = 1'b1; rf_waddr = 5'd31; rf_wdata = pc; end
      default: rf_we = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state decode and memory-port control; memory states stall while MIO_ready is low.
  always_comb begin
    state_d  = state_q;
    mem_w    = 1'b0;
    CPU_MIO  = 1'b0;
    Addr_out = alu_out;
    case (state_q)
      S_IF: begin
        CPU_MIO  = 1'b1;
        Addr_out = pc;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        case (op)
          OP_RTYPE: begin
            if (fn == FN_JR) state_d = S_JR;
            else if (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
                                FN_SLT, FN_SLL, FN_SRL}) state_d = S_REXE;
            else state_d = S_IF;
          end
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_d = S_IEXE;
          OP_LW, OP_SW: state_d = S_MADDR;
          OP_BEQ:  state_d = S_BEQ;
          OP_BNE:  state_d = S_BNE;
          OP_J:    state_d = S_J;
          OP_JAL:  state_d = S_JAL;
          default: state_d = S_IF;
        endcase
      end
      S_MADDR: state_d = (op == OP_LW) ? S_MRD : S_MWR;
      S_MRD: begin
        CPU_MIO = 1'b1;
        if (MIO_ready) state_d = S_LWWB;
      end
      S_MWR: begin
        CPU_MIO = 1'b1;
        mem_w   = 1'b1;
        if (MIO_ready) state_d = S_IF;
      end
      S_REXE:  state_d = S_RWB;
      S_IEXE:  state_d = S_IWB;
      default: state_d = S_IF;
    endcase
  end

  // Datapath registers: PC, IR, operand latches A/B, ALUOut and MDR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (state_q)
        S_IF: if (MIO_ready) begin
          ir <= Data_in;
          pc <= pc + 32'd4;
        end
        S_ID: begin
          a       <= rdata_a;
          b       <= rdata_b;
          alu_out <= branch_target;
        end
        S_MADDR, S_REXE, S_IEXE: alu_out <= alu_res;
        S_MRD:      if (MIO_ready) mdr <= Data_in;
        S_BEQ:      if (a == b) pc <= alu_out;
        S_BNE:      if (a != b) pc <= alu_out;
        S_J, S_JAL: pc <= {pc[31:28], ir[25:0], 2'b00};
        S_JR:       pc <= a;
        default:    ;
      endcase
    end
  end

  assign PC_out   = pc;
  assign inst_out = ir;
  assign Data_out = b;
  assign state    = state_q;

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// tb/tb_multi_cycle_cpu.sv - randomized self-checking bench with an instruction-level reference model
module tb_multi_cycle_cpu;

  localparam int S_IF = 0, S_ID = 1, S_MADDR = 2, S_MRD = 3, S_LWWB = 4, S_MWR = 5;
  localparam int S_REXE = 6, S_RWB = 7, S_BEQ = 8, S_J = 9, S_IEXE = 10, S_IWB = 11;
  localparam int S_JAL = 12, S_JR = 13, S_BNE = 14;

  logic        clk, reset, MIO_ready, INT;
  logic [31:0] Data_in, PC_out, inst_out, Addr_out, Data_out;
  logic        mem_w, CPU_MIO;
  logic [4:0]  state;

  logic [31:0] dut_mem [0:63];
  logic [31:0] mm      [0:63];
  logic [31:0] m_gpr   [0:31];
  logic [31:0] m_pc;
  int          exp_seq [$];
  logic [31:0] exp_addr, exp_wdata;
  int          tests_run = 0;
  int          tests_failed = 0;

  multi_cycle_cpu #(.RESET_PC(32'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .MIO_ready (MIO_ready),
    .INT       (INT),
    .Data_in   (Data_in),
    .PC_out    (PC_out),
    .inst_out  (inst_out),
    .mem_w     (mem_w),
    .Addr_out  (Addr_out),
    .Data_out  (Data_out),
    .CPU_MIO   (CPU_MIO),
    .state     (state)
  );

  assign Data_in = dut_mem[Addr_out[7:2]];

  initial clk = 1'b0;
  always #50 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic put(input int idx, input logic [31:0] w);
    mm[idx]      = w;
    dut_mem[idx] = w;
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
  endtask

  task automatic check_gprs(input string pfx);
    for (int r = 0; r < 32; r++)
      check($sformatf("%s_gpr%0d", pfx, r), dut.u_regs.regs[r], m_gpr[r]);
  endtask

  // Architectural effect of one instruction plus the state-code walk it should produce.
  task automatic model_step(input logic [31:0] ins);
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, wi;
    logic [31:0] va, vb, sx, zx, npc, newpc, res;
    logic        we;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
    sh = ins[10:6];  fn = ins[5:0];
    va = m_gpr[rs]; vb = m_gpr[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0, ins[15:0]};
    npc = m_pc + 32'd4; newpc = npc;
    we = 1'b0; wi = 5'd0; res = 32'h0;
    exp_addr = 32'h0; exp_wdata = 32'h0;
    exp_seq.delete();
    exp_seq.push_back(S_IF);
    exp_seq.push_back(S_ID);
    case (op)
      6'h00: begin
        we = 1'b1; wi = rd;
        case (fn)
          6'h20: res = va + vb;
          6'h22: res = va - vb;
          6'h24: res = va & vb;
          6'h25: res = va | vb;
          6'h26: res = va ^ vb;
          6'h27: res = ~(va | vb);
          6'h2A: res = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0;
          6'h00: res = vb << sh;
          6'h02: res = vb >> sh;
          6'h08: begin we = 1'b0; newpc = va; exp_seq.push_back(S_JR); end
          default: we = 1'b0;
        endcase
        if (we) begin exp_seq.push_back(S_REXE); exp_seq.push_back(S_RWB); end
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        we = 1'b1; wi = rt;
        case (op)
          6'h08:   res = va + sx;
          6'h0A:   res = ($signed(va) < $signed(sx)) ? 32'd1 : 32'd0;
          6'h0C:   res = va & zx;
          6'h0D:   res = va | zx;
          6'h0E:   res = va ^ zx;
          default: res = {ins[15:0], 16'h0};
        endcase
        exp_seq.push_back(S_IEXE); exp_seq.push_back(S_IWB);
      end
      6'h23: begin
        exp_addr = va + sx; res = mm[exp_addr[7:2]]; we = 1'b1; wi = rt;
        exp_seq.push_back(S_MADDR); exp_seq.push_back(S_MRD); exp_seq.push_back(S_LWWB);
      end
      6'h2B: begin
        exp_addr = va + sx; exp_wdata = vb; mm[exp_addr[7:2]] = vb;
        exp_seq.push_back(S_MADDR); exp_seq.push_back(S_MWR);
      end
      6'h04: begin exp_seq.push_back(S_BEQ); if (va == vb) newpc = npc + (sx << 2); end
      6'h05: begin exp_seq.push_back(S_BNE); if (va != vb) newpc = npc + (sx << 2); end
      6'h02: begin exp_seq.push_back(S_J); newpc = {npc[31:28], ins[25:0], 2'b00}; end
      6'h03: begin
        exp_seq.push_back(S_JAL); newpc = {npc[31:28], ins[25:0], 2'b00};
        we = 1'b1; wi = 5'd31; res = npc;
      end
      default: ;
    endcase
    if (we && wi != 5'd0) m_gpr[wi] = res;
    m_pc = newpc;
  endtask

  // mode 0: memory always ready; 1: random ready; 2: hold ready low 3 cycles in each memory state.
  task automatic run_instr(input int mode);
    logic [31:0] pc0, ins;
    int idx, held, guard, cur;
    logic rdy, is_mem;
    pc0 = m_pc;
    check("fetch_pc", PC_out, pc0);
    ins = mm[pc0[7:2]];
    model_step(ins);
    idx = 0; held = 0; guard = 0;
    while (idx < exp_seq.size() && guard < 100) begin
      guard++;
      cur = exp_seq[idx];
      is_mem = (cur == S_IF) || (cur == S_MRD) || (cur == S_MWR);
      check("state", 32'(state), 32'(cur));
      check("mem_w", 32'(mem_w), 32'(cur == S_MWR));
      check("cpu_mio", 32'(CPU_MIO), 32'(is_mem));
      if (cur == S_IF) begin
        check("fetch_addr", Addr_out, pc0);
      end else begin
        check("pc_after_fetch", PC_out, pc0 + 32'd4);
        check("ir", inst_out, ins);
      end
      if (cur == S_MRD || cur == S_MWR) check("mem_addr", Addr_out, exp_addr);
      if (cur == S_MWR) check("store_data", Data_out, exp_wdata);
      if (mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
        INT = 1'($urandom_range(0, 1));
      end else if (mode == 2 && is_mem && held < 3) rdy = 1'b0;
      else rdy = 1'b1;
      MIO_ready = rdy;
      if (mem_w && rdy) dut_mem[Addr_out[7:2]] = Data_out;
      if (is_mem && !rdy) held++;
      else begin idx++; held = 0; end
      @(negedge clk);
    end
    check_gprs("instr");
    if (ins[31:26] == 6'h2B) check("mem_word", dut_mem[exp_addr[7:2]], mm[exp_addr[7:2]]);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    int k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 8))
      0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h26;
      5: fn = 6'h27; 6: fn = 6'h2A; 7: fn = 6'h00; default: fn = 6'h02;
    endcase
    k = $urandom_range(0, 17);
    case (k)
      0, 1, 2: return enc_r(fn, rs, rt, rd, 5'($urandom));
      3:  return enc_i(6'h08, rs, rt, imm);
      4:  return enc_i(6'h0A, rs, rt, imm);
      5:  return enc_i(6'h0C, rs, rt, imm);
      6:  return enc_i(6'h0D, rs, rt, imm);
      7:  return enc_i(6'h0E, rs, rt, imm);
      8:  return enc_i(6'h0F, rs, rt, imm);
      9:  return enc_i(6'h23, rs, rt, imm);
      10: return enc_i(6'h2B, rs, rt, imm);
      11: return enc_i(6'h04, rs, rt, 16'($urandom_range(0, 8)) - 16'd4);
      12: return enc_i(6'h05, rs, rt, 16'($urandom_range(0, 8)) - 16'd4);
      13: return {6'h02, 26'($urandom_range(0, 63))};
      14: return {6'h03, 26'($urandom_range(0, 63))};
      15: return enc_r(6'h08, rs, 5'd0, 5'd0, 5'd0);
      16: return enc_r(6'h3F, rs, rt, rd, 5'd0);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; MIO_ready = 1'b1; INT = 1'b0;
    for (int i = 0; i < 64; i++) put(i, 32'h0);
    put(0, 32'h2009000A);
    put(1, 32'h200AFFFB);
    put(2, 32'h152A0000);
    put(3, 32'h35280000);
    put(4, 32'h39280000);
    put(5, 32'h3C0B0006);
    put(6, 32'h294D0000);
    put(7, 32'h0C000002);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'(S_IF));
    check("rst_pc", PC_out, 32'h0);
    check("rst_mem_w", 32'(mem_w), 32'h0);
    check("rst_cpu_mio", 32'(CPU_MIO), 32'h1);
    check("rst_ir", inst_out, 32'h0);
    check("rst_addr", Addr_out, 32'h0);
    reset = 1'b0;
    for (int n = 0; n < 9; n++) run_instr(0);

    repeat (2) @(negedge clk);
    #10 reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'(S_IF));
    check("abort_pc", PC_out, 32'h0);
    check("abort_ir", inst_out, 32'h0);
    model_reset();
    check_gprs("abort");

    for (int i = 0; i < 64; i++) put(i, 32'h0);
    put(0,  enc_r(6'h27, 5'd0, 5'd0, 5'd8, 5'd0));
    put(1,  enc_i(6'h08, 5'd0, 5'd9, 16'h1234));
    put(2,  enc_i(6'h08, 5'd0, 5'd10, 16'hFFFB));
    put(3,  enc_r(6'h20, 5'd9, 5'd10, 5'd11, 5'd0));
    put(4,  enc_r(6'h22, 5'd9, 5'd10, 5'd12, 5'd0));
    put(5,  enc_r(6'h24, 5'd9, 5'd10, 5'd13, 5'd0));
    put(6,  enc_r(6'h25, 5'd9, 5'd10, 5'd14, 5'd0));
    put(7,  enc_r(6'h26, 5'd9, 5'd10, 5'd15, 5'd0));
    put(8,  enc_r(6'h2A, 5'd10, 5'd9, 5'd17, 5'd0));
    put(9,  enc_r(6'h00, 5'd0, 5'd10, 5'd16, 5'd0));
    put(10, enc_r(6'h02, 5'd0, 5'd10, 5'd18, 5'd4));
    put(11, enc_r(6'h00, 5'd0, 5'd9, 5'd19, 5'd3));
    put(12, enc_i(6'h08, 5'd0, 5'd8, 16'h0010));
    put(13, enc_i(6'h2B, 5'd8, 5'd9, 16'h0000));
    put(14, 32'h8D2A0004);
    put(15, enc_i(6'h04, 5'd0, 5'd0, 16'h0001));
    put(16, enc_i(6'h08, 5'd0, 5'd20, 16'h0001));
    put(17, 32'hFC000000);
    put(18, enc_r(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0));
    put(19, enc_r(6'h08, 5'd31, 5'd0, 5'd0, 5'd0));
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 20; n++) run_instr((n == 13 || n == 14) ? 2 : 0);

    reset = 1'b1;
    for (int i = 0; i < 64; i++) put(i, rand_instr());
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 300; n++) run_instr(1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
